// File: rtl/dram_path_scheduler_if.sv
// Request, DRAM command and path-buffer handshake bundle for dram_path_scheduler.
// The slave modport is the scheduler's view; master is the requester/DRAM side.
interface dram_path_scheduler_if #(
  parameter int ORAML     = 10,
  parameter int DDRAWidth = 30,
  parameter int DDRCWidth = 3
);
  logic                 AccessValid;
  logic                 AccessReady;
  logic [ORAML-1:0]     AccessLeaf;
  logic [1:0]           AccessMode;
  logic [DDRCWidth-1:0] DRAMCommand;
  logic [DDRAWidth-1:0] DRAMAddress;
  logic                 DRAMCommandValid;
  logic                 DRAMCommandReady;
  logic                 DRAMReadDataValid;
  logic                 BufPop;
  logic                 DRAMWriteDataValid;
  logic                 DRAMWriteDataReady;
  logic                 AccessDone;
  logic                 Busy;

  modport master (
    output AccessValid, AccessLeaf, AccessMode, DRAMCommandReady, DRAMReadDataValid,
           BufPop, DRAMWriteDataValid, DRAMWriteDataReady,
    input  AccessReady, DRAMCommand, DRAMAddress, DRAMCommandValid, AccessDone, Busy
  );

  modport slave (
    input  AccessValid, AccessLeaf, AccessMode, DRAMCommandReady, DRAMReadDataValid,
           BufPop, DRAMWriteDataValid, DRAMWriteDataReady,
    output AccessReady, DRAMCommand, DRAMAddress, DRAMCommandValid, AccessDone, Busy
  );
endinterface

// File: rtl/dram_path_scheduler.sv
// Walks one ORAM tree path root-to-leaf, issuing DRAM burst reads then writes,
// throttled by path-buffer occupancy (reads) and write-data credit (writes).
module dram_path_scheduler #(
  parameter int ORAML      = 10,
  parameter int BktBursts  = 4,
  parameter int DDRAWidth  = 30,
  parameter int DDRCWidth  = 3,
  parameter int BurstShift = 3,
  parameter int BufDepth   = 64
) (
  input  logic                  Clock,
  input  logic                  Reset,
  dram_path_scheduler_if.slave  bus
);
  localparam int N    = (ORAML + 1) * BktBursts;
  localparam int LvlW = (ORAML > 0) ? $clog2(ORAML + 1) : 1;
  localparam int BW   = (BktBursts > 1) ? $clog2(BktBursts) : 1;
  localparam int OccW = $clog2(BufDepth + 1);
  localparam int CntW = $clog2(N + 1);

  localparam logic [LvlW-1:0]      LastLvl  = LvlW'(ORAML);
  localparam logic [BW-1:0]        LastB    = BW'(BktBursts - 1);
  localparam logic [CntW-1:0]      NCnt     = CntW'(N);
  localparam logic [OccW-1:0]      OccFull  = OccW'(BufDepth);
  localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);
  localparam logic [DDRCWidth-1:0] CmdWrite = '0;

  typedef enum logic [1:0] {IDLE, READ, RDWAIT, WRITE} state_e;

  state_e               state_q, state_d;
  logic [ORAML-1:0]     leaf_q, leaf_d;
  logic [1:0]           mode_q, mode_d;
  logic [LvlW-1:0]      lvl_q, lvl_d;
  logic [BW-1:0]        b_q, b_d;
  logic [OccW-1:0]      occ_q, occ_d;
  logic [CntW-1:0]      wcr_q, wcr_d;
  logic [CntW-1:0]      ret_q, ret_d;
  logic                 done_q, done_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [DDRCWidth-1:0] cmd_q, cmd_d;
  logic [DDRAWidth-1:0] addr_q, addr_d;

  logic cmd_hs, rd_hs, wr_hs, wd_hs, pop_ok, last_burst;

  // Level-l node on the path is (2^l - 1) + (leaf >> (ORAML - l)).
  function automatic logic [DDRAWidth-1:0] burst_addr(input logic [LvlW-1:0]  lvl,
                                                      input logic [ORAML-1:0] leaf,
                                                      input logic [BW-1:0]    b);
    logic [63:0] node;
    node = ((64'd1 << lvl) - 64'd1) + (64'(leaf) >> (ORAML - int'(lvl)));
    return DDRAWidth'((node * 64'(BktBursts) + 64'(b)) << BurstShift);
  endfunction

  always_comb begin
    state_d    = state_q;
    leaf_d     = leaf_q;
    mode_d     = mode_q;
    lvl_d      = lvl_q;
    b_d        = b_q;
    occ_d      = occ_q;
    wcr_d      = wcr_q;
    ret_d      = ret_q;
    done_d     = 1'b0;
    cmd_hs     = cmd_valid_q && bus.DRAMCommandReady;
    rd_hs      = cmd_hs && (state_q == READ);
    wr_hs      = cmd_hs && (state_q == WRITE);
    wd_hs      = bus.DRAMWriteDataValid && bus.DRAMWriteDataReady;
    pop_ok     = bus.BufPop && (occ_q != '0);
    last_burst = (lvl_q == LastLvl) && (b_q == LastB);

    if (rd_hs && !pop_ok)      occ_d = occ_q + OccW'(1);
    else if (!rd_hs && pop_ok) occ_d = occ_q - OccW'(1);

    if (state_q != IDLE) begin
      if (wd_hs && !wr_hs && (wcr_q != NCnt)) wcr_d = wcr_q + CntW'(1);
      else if (!wd_hs && wr_hs)               wcr_d = wcr_q - CntW'(1);
    end

    // Returns may overlap the tail of the read-issue phase, so count them in READ too.
    if (((state_q == READ) || (state_q == RDWAIT)) && bus.DRAMReadDataValid && (ret_q != NCnt))
      ret_d = ret_q + CntW'(1);

    if (cmd_hs) begin
      if (b_q == LastB) begin
        b_d   = '0;
        lvl_d = lvl_q + LvlW'(1);
      end else begin
        b_d = b_q + BW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        wcr_d = '0;
        if (bus.AccessValid) begin
          leaf_d = bus.AccessLeaf;
          mode_d = bus.AccessMode;
          lvl_d  = '0;
          b_d    = '0;
          ret_d  = '0;
          case (bus.AccessMode)
            2'b01, 2'b11: state_d = READ;
            2'b10:        state_d = WRITE;
            default:      done_d  = 1'b1;
          endcase
        end
      end
      READ: begin
        if (rd_hs && last_burst) begin
          state_d = RDWAIT;
          lvl_d   = '0;
          b_d     = '0;
        end
      end
      RDWAIT: begin
        if (ret_d == NCnt) begin
          if (mode_q == 2'b11) begin
            state_d = WRITE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WRITE: begin
        if (wr_hs && last_burst) begin
          state_d = IDLE;
          done_d  = 1'b1;
          wcr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Command outputs are registered from next state; they only change on handshake.
    cmd_valid_d = ((state_d == READ) && (occ_d < OccFull)) ||
                  ((state_d == WRITE) && (wcr_d != '0));
    cmd_d       = (state_d == READ) ? CmdRead : CmdWrite;
    addr_d      = ((state_d == READ) || (state_d == WRITE)) ? burst_addr(lvl_d, leaf_d, b_d) : '0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      leaf_q      <= '0;
      mode_q      <= '0;
      lvl_q       <= '0;
      b_q         <= '0;
      occ_q       <= '0;
      wcr_q       <= '0;
      ret_q       <= '0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      leaf_q      <= leaf_d;
      mode_q      <= mode_d;
      lvl_q       <= lvl_d;
      b_q         <= b_d;
      occ_q       <= occ_d;
      wcr_q       <= wcr_d;
      ret_q       <= ret_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
    end
  end

`ifdef SIMULATION
  always @(posedge Clock) begin
    if (Reset && bus.BufPop && (occ_q == '0))
      $warning("BufPop with empty path buffer ignored");
  end
`endif

  assign bus.AccessReady      = (state_q == IDLE);
  assign bus.Busy             = (state_q != IDLE);
  assign bus.AccessDone       = done_q;
  assign bus.DRAMCommandValid = cmd_valid_q;
  assign bus.DRAMCommand      = cmd_q;
  assign bus.DRAMAddress      = addr_q;
endmodule

// File: tb/tb_dram_path_scheduler.sv
// Scoreboard bench for dram_path_scheduler: directed accesses push expected
// DRAM commands; a negedge monitor pops and compares on every command handshake.
module tb_dram_path_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_path_scheduler_if #(.ORAML(2), .DDRAWidth(30), .DDRCWidth(3)) bus ();

  dram_path_scheduler #(
    .ORAML(2), .BktBursts(2), .DDRAWidth(30), .DDRCWidth(3), .BurstShift(3), .BufDepth(4)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  cmd;
    logic [29:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  int   tb_occ    = 0;
  int   tb_credit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input logic [2:0] cmd, input logic [29:0] addr);
    exp_t e;
    e.cmd  = cmd;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] mode, input logic [1:0] leaf);
    cycle();
    bus.AccessValid = 1'b1;
    bus.AccessMode  = mode;
    bus.AccessLeaf  = leaf;
    @(negedge clk);
    chk("access_ready", bus.AccessReady, 1);
    cycle();
    bus.AccessValid = 1'b0;
  endtask

  task automatic wait_q_size(input string name, input int size, input int budget);
    int n = 0;
    while (exp_q.size() > size && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, exp_q.size(), size);
  endtask

  task automatic wait_done(input string name, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, done_cnt, target);
  endtask

  task automatic drain();
    int n;
    cycle();
    n = tb_occ;
    bus.BufPop = 1'b1;
    repeat (n) cycle();
    bus.BufPop = 1'b0;
  endtask

  // Monitor: scoreboard pops, buffer-occupancy and write-credit tracking, done counting.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_occ    = 0;
      tb_credit = 0;
    end else begin
      if (bus.DRAMCommandValid && bus.DRAMCommandReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd got cmd=%0d addr=%0d required none",
                   bus.DRAMCommand, bus.DRAMAddress);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cmd_code", bus.DRAMCommand, mon_e.cmd);
          chk("cmd_addr", bus.DRAMAddress, mon_e.addr);
        end
        if (bus.DRAMCommand == 3'b000) begin
          chk("wr_credit_avail", tb_credit > 0, 1);
          tb_credit--;
        end else begin
          tb_occ++;
        end
      end
      if (bus.DRAMWriteDataValid && bus.DRAMWriteDataReady) tb_credit++;
      if (bus.BufPop && tb_occ > 0) tb_occ--;
      if (bus.AccessDone) done_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                  = 1'b0;
    bus.AccessValid        = 1'b0;
    bus.AccessLeaf         = '0;
    bus.AccessMode         = '0;
    bus.DRAMCommandReady   = 1'b0;
    bus.DRAMReadDataValid  = 1'b0;
    bus.BufPop             = 1'b0;
    bus.DRAMWriteDataValid = 1'b0;
    bus.DRAMWriteDataReady = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", bus.DRAMCommandValid, 0);
    chk("rst_done", bus.AccessDone, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_cmd", bus.DRAMCommand, 0);
    chk("rst_addr", bus.DRAMAddress, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", bus.AccessReady, 1);
    chk("rel_busy", bus.Busy, 0);

    // Read-only, leaf 3: four issue, stall at full buffer, two pops release the rest
    bus.DRAMCommandReady = 1'b1;
    push(3'b001, 30'd0);  push(3'b001, 30'd8);
    push(3'b001, 30'd32); push(3'b001, 30'd40);
    push(3'b001, 30'd96); push(3'b001, 30'd104);
    accept(2'b01, 2'd3);
    @(negedge clk);
    chk("rd_latency", bus.DRAMCommandValid, 1);
    wait_q_size("rd_first4", 2, 50);
    repeat (4) @(negedge clk);
    chk("rd_stall_valid", bus.DRAMCommandValid, 0);
    chk("rd_stall_left", exp_q.size(), 2);
    chk("rd_busy", bus.Busy, 1);
    cycle();
    bus.BufPop = 1'b1;
    cycle();
    cycle();
    bus.BufPop = 1'b0;
    wait_q_size("rd_last2", 0, 50);
    chk("rd_busy_wait", bus.Busy, 1);
    cycle();
    bus.DRAMReadDataValid = 1'b1;
    repeat (5) cycle();
    bus.DRAMReadDataValid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rd_no_early_done", done_cnt, 0);
    cycle();
    bus.DRAMReadDataValid = 1'b1;
    cycle();
    bus.DRAMReadDataValid = 1'b0;
    wait_done("rd_done", 1, 20);
    chk("rd_idle_busy", bus.Busy, 0);
    chk("rd_idle_ready", bus.AccessReady, 1);
    drain();

    // Write-only, leaf 0: each command gated by a prior write-data handshake
    push(3'b000, 30'd0);  push(3'b000, 30'd8);
    push(3'b000, 30'd16); push(3'b000, 30'd24);
    push(3'b000, 30'd48); push(3'b000, 30'd56);
    accept(2'b10, 2'd0);
    @(negedge clk);
    chk("wr_no_credit", bus.DRAMCommandValid, 0);
    cycle();
    bus.DRAMWriteDataValid = 1'b1;
    cycle();
    bus.DRAMWriteDataValid = 1'b0;
    repeat (2) cycle();
    @(negedge clk);
    chk("wr_half_hs", bus.DRAMCommandValid, 0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      bus.DRAMWriteDataValid = 1'b1;
      bus.DRAMWriteDataReady = 1'b1;
      cycle();
      bus.DRAMWriteDataValid = 1'b0;
      bus.DRAMWriteDataReady = 1'b0;
      repeat (2) cycle();
    end
    wait_q_size("wr_all", 0, 50);
    wait_done("wr_done", 2, 20);

    // Read-only, leaf 2: held command stays stable, then pop coincides with issue at occ=3
    bus.DRAMCommandReady = 1'b0;
    push(3'b001, 30'd0);  push(3'b001, 30'd8);
    push(3'b001, 30'd32); push(3'b001, 30'd40);
    push(3'b001, 30'd80); push(3'b001, 30'd88);
    accept(2'b01, 2'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.DRAMCommandValid, 1);
      chk("hold_addr", bus.DRAMAddress, 0);
      chk("hold_cmd", bus.DRAMCommand, 1);
      cycle();
    end
    bus.DRAMCommandReady = 1'b1;
    repeat (3) cycle();
    bus.BufPop = 1'b1;
    cycle();
    bus.BufPop = 1'b0;
    @(negedge clk);
    chk("occ3_issue_continues", bus.DRAMCommandValid, 1);
    cycle();
    @(negedge clk);
    chk("occ4_stall", bus.DRAMCommandValid, 0);
    cycle();
    bus.BufPop = 1'b1;
    cycle();
    cycle();
    bus.BufPop = 1'b0;
    wait_q_size("hold_all", 0, 50);
    bus.DRAMReadDataValid = 1'b1;
    repeat (6) cycle();
    bus.DRAMReadDataValid = 1'b0;
    wait_done("hold_done", 3, 20);
    drain();

    // Read-then-write, leaf 1, reset after third read command
    bus.DRAMCommandReady = 1'b1;
    push(3'b001, 30'd0); push(3'b001, 30'd8); push(3'b001, 30'd16);
    accept(2'b11, 2'd1);
    wait_q_size("mid_three", 0, 50);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.DRAMCommandValid, 0);
    chk("mid_rst_cmd", bus.DRAMCommand, 0);
    chk("mid_rst_addr", bus.DRAMAddress, 0);
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_done", bus.AccessDone, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", bus.AccessReady, 1);
    repeat (10) cycle();
    chk("mid_no_done", done_cnt, 3);
    chk("mid_no_cmd", bus.DRAMCommandValid, 0);

    // Null access
    accept(2'b00, 2'd0);
    @(negedge clk);
    chk("null_done", bus.AccessDone, 1);
    chk("null_busy", bus.Busy, 0);
    chk("null_valid", bus.DRAMCommandValid, 0);
    @(negedge clk);
    chk("null_done_pulse", bus.AccessDone, 0);

    repeat (5) cycle();
    chk("done_total", done_cnt, 4);
    chk("exp_left", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_path_scheduler.md
DRAM_PATH_SCHEDULER -- requirements
Module: dram_path_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ORAML, 10: tree depth; a path holds ORAML+1 buckets.
- BktBursts, 4: DRAM bursts per bucket.
- DDRAWidth, 30: DRAM address width.
- DDRCWidth, 3: DRAM command width.
- BurstShift, 3: left shift from burst index to DRAM address.
- BufDepth, 64: read path-buffer capacity in bursts; BufDepth >= BktBursts.
REQ-002 Ports (name, direction, width, meaning), one per line; the block uses one clock, and reset is asynchronous and active-low:
- Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-low reset.
- AccessValid  in  1  path access request.
- AccessReady  out  1  request accepted when high together with AccessValid.
- AccessLeaf  in  ORAML  leaf of the path.
- AccessMode  in  2  01 read-only, 10 write-only, 11 read then write, 00 null.
- DRAMCommand  out  DDRCWidth  001 read, 000 write.
- DRAMAddress  out  DDRAWidth  burst address.
- DRAMCommandValid  out  1  command offered.
- DRAMCommandReady  in  1  command taken.
- DRAMReadDataValid  in  1  one read burst returned into the path buffer.
- BufPop  in  1  consumer removed one burst from the path buffer.
- DRAMWriteDataValid  in  1  write-data handshake observe.
- DRAMWriteDataReady  in  1  write-data handshake observe.
- AccessDone  out  1  one-cycle completion pulse.
- Busy  out  1  high whenever state is not IDLE.

Function
REQ-003 N = (ORAML+1)*BktBursts bursts per phase.
REQ-004 Bucket order is root to leaf in both phases; level l node = (2^l - 1) + (AccessLeaf >> (ORAML-l)); AccessLeaf is latched at acceptance.
REQ-005 Burst address = (node*BktBursts + b) << BurstShift, for b = 0..BktBursts-1, truncated to DDRAWidth.
REQ-006 States are IDLE, READ, RDWAIT, WRITE. AccessReady = 1 only in IDLE.
REQ-007 IDLE transitions on acceptance: mode 01/11 to READ, 10 to WRITE, 00 stays in IDLE with AccessDone pulsed the next cycle.
REQ-008 The first DRAMCommandValid asserts in the cycle after acceptance (latency 1).
REQ-009 Once asserted, DRAMCommandValid, DRAMCommand and DRAMAddress hold stable until DRAMCommandReady; the burst index advances only on handshake.
REQ-010 Occupancy counter occ (width clog2(BufDepth+1)): +1 on read-command handshake, -1 on BufPop; both together leaves occ unchanged; BufPop at occ=0 is ignored and flagged under SIMULATION.
REQ-011 In READ, DRAMCommandValid is asserted only when occ < BufDepth; at occ = BufDepth issue stalls.
REQ-012 READ moves to RDWAIT after N read handshakes; RDWAIT counts DRAMReadDataValid until N returns (returns arriving during READ also count).
REQ-013 On the Nth return: mode 11 goes to WRITE; mode 01 goes to IDLE with AccessDone pulsed.
REQ-014 Write credit wcr: +1 per DRAMWriteDataValid&DRAMWriteDataReady, -1 per write-command handshake, saturating at N.
REQ-015 In WRITE, DRAMCommandValid is asserted only when wcr > 0.
REQ-016 The Nth write handshake goes to IDLE with AccessDone pulsed in the first IDLE cycle.
REQ-017 AccessValid is ignored outside IDLE. occ persists across accesses; wcr clears on entering IDLE.

Reset
REQ-018 With Reset low: state IDLE; all counters 0; DRAMCommandValid=0, AccessDone=0, Busy=0, DRAMCommand=0, DRAMAddress=0.
REQ-019 AccessReady=1 in the first edge after release.
REQ-020 Reset mid-access abandons it; no AccessDone is generated.

Verification (ORAML=2, BktBursts=2, BurstShift=3, BufDepth=4, N=6)
REQ-021 Read-only, leaf 3, Ready=1, no BufPop:
- commands 001 at 0, 8, 32, 40, then stall at occ=4.
- popping 2 releases 96 and 104.
- 6 returns give AccessDone.
REQ-022 Write-only, leaf 0: commands 000 at 0, 8, 16, 24, 48, 56, each issued no earlier than the cycle after its write-data handshake.
REQ-023 DRAMCommandReady held low 5 cycles with Valid=1: address and command stable; exactly one command counted at release.
REQ-024 At occ=3, read handshake and BufPop in the same cycle: occ stays 3 and issue continues.
REQ-025 Reset asserted after 3 read commands of mode 11: outputs zero immediately, AccessReady=1 after release, no AccessDone.
REQ-026 Mode 00 accepted: no DRAM commands; AccessDone one cycle later; Busy stays 0.
